neuron_mac_q16: RTL and testbench
=================================

# neuron_mac_q16

Fixed-point neuron pre-activation stage that sits directly upstream of the tanh activation unit. It accepts a bias, then streams K (input, weight) pairs. It forms bias + Σ x·w in full precision, truncates to Q16.16 with saturation, and holds the result for the activation stage through a valid/ready handshake. It runs once per neuron evaluation in both the forward and training passes.

## Interface
- N, 32, data width; signed two's-complement Q(N-FRAC).FRAC.
- FRAC, 16, fractional bits; one = 1<<FRAC.
- K, 8, fan-in (pairs per evaluation), ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- bias  in  N  Q16.16 bias, captured with start.
- in_valid  in  1  x_in/w_in pair valid.
- in_ready  out  1  pair accepted when in_valid & in_ready.
- x_in  in  N  Q16.16 activation input.
- w_in  in  N  Q16.16 weight.
- out  out  N  saturated Q16.16 pre-activation; drives the tanh x_in.
- out_valid  out  1  out is valid; held until accepted.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- sat  out  1  the result in out was clipped; valid with out_valid.

## Operation
- Accumulator width: ACC_W = 2N + clog2(K+1) bits, Q.2FRAC. It holds the exact sum, so it never wraps.
- States:
  - IDLE: in_ready=0. On start, acc ← sign_ext(bias) << FRAC, cnt ← 0, prod_v ← 0, then go to ACCUM.
  - ACCUM: in_ready=1. On accept: prod ← signed x_in·w_in (2N bits), prod_v ← 1, cnt ← cnt+1. On every edge with prod_v=1: acc ← acc + sign_ext(prod), and prod_v clears unless a new pair is accepted that same edge. When the K-th pair is accepted, go to DRAIN.
  - DRAIN: in_ready=0. Add the final prod, then go to RESULT.
  - RESULT: out ← sat_trunc(acc), sat set if clipped, out_valid ← 1, then go to HOLD.
  - HOLD: out, out_valid and sat are stable. On out_ready, out_valid ← 0 and go to IDLE.
- Truncation: r = acc >>> FRAC (arithmetic shift, i.e. floor toward −∞). No rounding.
- Saturation: if r > 2^(N-1)−1, out = 0x7FFFFFFF. If r < −2^(N-1), out = 0x80000000. Otherwise out = r[N-1:0].
- start outside IDLE is ignored.
- in_valid outside ACCUM is ignored; no pair is consumed.
- Gaps in in_valid are allowed. Accumulation proceeds only on accepted pairs.
- Reset while active discards the evaluation. No partial result is emitted.

## Timing
- Reset values: in_ready=0, out_valid=0, out=0, sat=0, state=IDLE, cnt=0, prod_v=0, acc=0.
- Multiplier is one registered stage; the adder is one stage.
- Latency: out_valid rises 2 edges after the edge that accepts the K-th pair (DRAIN edge, then RESULT edge).
- Minimum evaluation: 1 (start) + K + 2 edges, then the handshake.
- Back-to-back operation: start may be asserted on the same cycle HOLD is exited. It is sampled on the following cycle (IDLE).
- in_ready is a pure function of state, with no combinational path from in_valid.
- out_valid is registered.
- The consumer may hold out_ready high continuously. HOLD then lasts exactly 1 cycle.

## Structure
- Shared package q16_pkg:
  - constants N, FRAC, Q_ONE (0x00010000), Q_MAX (0x7FFFFFFF), Q_MIN (0x80000000);
  - state enum {IDLE, ACCUM, DRAIN, RESULT, HOLD}.
- Sub-module q16_sat_trunc: combinational, ACC_W in, N out plus a sat flag. It is reusable by the downstream error and derivative stages.

## Test plan
- K=4, bias=0x00010000, four pairs x=0x00010000, w=0x00008000 → out=0x00030000, sat=0, out_valid 2 edges after the 4th accept.
- K=4, bias=0, x=0xFFFE8000 (−1.5), w=0x00020000 (2.0) ×4 → out=0xFFF40000 (−12.0).
- K=4, x=w=0x7FFF0000 ×4 → out=0x7FFFFFFF, sat=1. Negating w gives out=0x80000000, sat=1.
- Truncation, K=4 with the other pairs 0:
  - x=0x00000001, w=0x00008000 → out=0x00000000;
  - x=0xFFFFFFFF, w=0x00008000 → out=0xFFFFFFFF (floor).
- Random in_valid gaps, out_ready held low 5 cycles, then start asserted during HOLD → result matches the reference model; HOLD values stable; start ignored; the next evaluation starts only from IDLE.
- rst_n asserted mid-ACCUM after 2 pairs → all outputs return to reset values immediately. A fresh evaluation after release gives the correct result with no residue.

Source files
------------

// File: rtl/q16_pkg.sv
// Shared Q16.16 fixed-point definitions for the neuron datapath stages.
package q16_pkg;

    localparam int N    = 32;
    localparam int FRAC = 16;

    localparam logic [N-1:0] Q_ONE = 32'h0001_0000;
    localparam logic [N-1:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [N-1:0] Q_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        RESULT,
        HOLD
    } state_t;

endpackage

// File: rtl/q16_sat_trunc.sv
// Reduces a wide Q.2FRAC accumulator to saturated Q16.16 by flooring away
// the extra fractional bits and clipping anything outside the N-bit range.
module q16_sat_trunc
    import q16_pkg::*;
#(
    parameter int ACC_W = 68
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [N-1:0]     res_o,
    output logic             sat_o
);

    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-N:0]        upper;

    // The value fits in N bits only when every bit from N-1 upward matches the sign.
    always_comb begin
        shifted = $signed(acc_i) >>> FRAC;
        upper   = shifted[ACC_W-1:N-1];
        res_o   = shifted[N-1:0];
        sat_o   = 1'b0;
        if ((|upper) && !(&upper)) begin
            sat_o = 1'b1;
            res_o = shifted[ACC_W-1] ? Q_MIN : Q_MAX;
        end
    end

endmodule

// File: rtl/neuron_mac_q16.sv
// Neuron pre-activation: bias + sum of K products in exact precision, then
// floored and saturated to Q16.16 and held behind a valid/ready handshake.
module neuron_mac_q16
    import q16_pkg::*;
#(
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] bias,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] w_in,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sat
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int ACC_W = 2 * N + CNT_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]     prod_q, prod_d;
    logic               prod_v_q, prod_v_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [N-1:0]       out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               sat_q, sat_d;

    logic [N-1:0]       trunc_res;
    logic               trunc_sat;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   bias_ext;
    logic [2*N-1:0]     x_ext;
    logic [2*N-1:0]     w_ext;

    q16_sat_trunc #(
        .ACC_W (ACC_W)
    ) u_sat_trunc (
        .acc_i (acc_q),
        .res_o (trunc_res),
        .sat_o (trunc_sat)
    );

    // Sign extensions feeding the multiplier and the accumulator.
    always_comb begin
        prod_ext = {{(ACC_W - 2 * N){prod_q[2*N-1]}}, prod_q};
        bias_ext = {{(ACC_W - N - FRAC){bias[N-1]}}, bias, {FRAC{1'b0}}};
        x_ext    = {{N{x_in[N-1]}}, x_in};
        w_ext    = {{N{w_in[N-1]}}, w_in};
    end

    // Next-state and datapath updates; the product register drains into acc one edge later.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        prod_v_d    = prod_v_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = bias_ext;
                    cnt_d    = '0;
                    prod_v_d = 1'b0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (prod_v_q) begin
                    acc_d = acc_q + prod_ext;
                end
                if (in_valid) begin
                    prod_d   = x_ext * w_ext;
                    prod_v_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(K - 1)) begin
                        state_d = DRAIN;
                    end
                end else begin
                    prod_v_d = 1'b0;
                end
            end
            DRAIN: begin
                if (prod_v_q) begin
                    acc_d = acc_q + prod_ext;
                end
                prod_v_d = 1'b0;
                state_d  = RESULT;
            end
            RESULT: begin
                out_d       = trunc_res;
                sat_d       = trunc_sat;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any evaluation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    // Pair acceptance depends only on state, never on in_valid.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out       = out_q;
        out_valid = out_valid_q;
        sat       = sat_q;
    end

endmodule

// File: tb/tb_neuron_mac_q16.sv
// Self-checking bench for neuron_mac_q16 with K=4: directed corner cases
// plus randomized evaluations compared against a wide-integer reference.
module tb_neuron_mac_q16;
    import q16_pkg::*;

    localparam int KT = 4;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [31:0] bias;
    logic        inValid;
    logic        inReady;
    logic [31:0] xIn;
    logic [31:0] wIn;
    logic [31:0] outVal;
    logic        outValid;
    logic        outReady;
    logic        sat;

    logic [31:0] xArr [KT];
    logic [31:0] wArr [KT];
    int          checks;
    int          errors;

    neuron_mac_q16 #(
        .K (KT)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .start     (start),
        .bias      (bias),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .x_in      (xIn),
        .w_in      (wIn),
        .out       (outVal),
        .out_valid (outValid),
        .out_ready (outReady),
        .sat       (sat)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Exact arithmetic: bias*2^FRAC + sum(x*w), floor by 2^FRAC, clamp to 32-bit signed.
    function automatic void refModel(input logic [31:0] b, output logic [31:0] o, output logic s);
        logic signed [127:0] acc;
        logic signed [127:0] r;
        logic signed [127:0] limHi;
        logic signed [127:0] limLo;
        limHi = 128'sd2147483647;
        limLo = -128'sd2147483648;
        acc = $signed({{96{b[31]}}, b}) * 128'sd65536;
        for (int i = 0; i < KT; i++) begin
            acc = acc + $signed({{96{xArr[i][31]}}, xArr[i]}) * $signed({{96{wArr[i][31]}}, wArr[i]});
        end
        r = acc >>> 16;
        if (r > limHi) begin
            o = 32'h7FFF_FFFF;
            s = 1'b1;
        end else if (r < limLo) begin
            o = 32'h8000_0000;
            s = 1'b1;
        end else begin
            o = r[31:0];
            s = 1'b0;
        end
    endfunction

    function automatic logic [31:0] randQ();
        logic signed [31:0] v;
        v = $urandom();
        return v >>> $urandom_range(0, 20);
    endfunction

    task automatic startEval(input logic [31:0] b);
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkVal("ready_in_accum", 32'(inReady), 32'd1);
    endtask

    // Feeds the K pairs, optionally with idle gaps and stray start pulses, then checks latency.
    task automatic applyStimulus(input bit gaps);
        for (int i = 0; i < KT; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    inValid = 1'b0;
                    xIn     = $urandom();
                    wIn     = $urandom();
                    start   = 1'($urandom_range(0, 1));
                    bias    = $urandom();
                    tick();
                end
            end
            start   = 1'b0;
            inValid = 1'b1;
            xIn     = xArr[i];
            wIn     = wArr[i];
            tick();
        end
        inValid = 1'b0;
        xIn     = $urandom();
        wIn     = $urandom();
        checkVal("ready_after_last", 32'(inReady), 32'd0);
        checkVal("valid_lat0", 32'(outValid), 32'd0);
        tick();
        checkVal("valid_lat1", 32'(outValid), 32'd0);
        tick();
        checkVal("valid_lat2", 32'(outValid), 32'd1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expOut, input logic expSat);
        checkVal({tag, "_out"}, outVal, expOut);
        checkVal({tag, "_sat"}, 32'(sat), 32'(expSat));
    endtask

    task automatic finishHandshake();
        outReady = 1'b1;
        tick();
        checkVal("valid_drop", 32'(outValid), 32'd0);
        outReady = 1'b0;
    endtask

    task automatic setPairs(input logic [31:0] x0, input logic [31:0] w0,
                            input logic [31:0] x1, input logic [31:0] w1);
        xArr[0] = x0; wArr[0] = w0;
        for (int i = 1; i < KT; i++) begin
            xArr[i] = x1;
            wArr[i] = w1;
        end
    endtask

    logic [31:0] expOut;
    logic        expSat;
    logic [31:0] b;

    // Linear sequence of directed and randomized evaluations.
    initial begin
        checks   = 0;
        errors   = 0;
        rstN     = 1'b0;
        start    = 1'b0;
        bias     = '0;
        inValid  = 1'b0;
        xIn      = '0;
        wIn      = '0;
        outReady = 1'b0;

        tick();
        checkVal("rst_in_ready", 32'(inReady), 32'd0);
        checkVal("rst_out_valid", 32'(outValid), 32'd0);
        checkVal("rst_out", outVal, 32'd0);
        checkVal("rst_sat", 32'(sat), 32'd0);
        rstN = 1'b1;
        tick();
        checkVal("idle_in_ready", 32'(inReady), 32'd0);

        // 1 + 4 * 0.5 = 3.0
        setPairs(Q_ONE, 32'h0000_8000, Q_ONE, 32'h0000_8000);
        startEval(Q_ONE);
        applyStimulus(1'b0);
        checkOutput("basic", 32'h0003_0000, 1'b0);
        finishHandshake();

        // 4 * (-1.5 * 2.0) = -12.0
        setPairs(32'hFFFE_8000, 32'h0002_0000, 32'hFFFE_8000, 32'h0002_0000);
        startEval(32'h0);
        applyStimulus(1'b0);
        checkOutput("negative", 32'hFFF4_0000, 1'b0);
        finishHandshake();

        setPairs(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
        startEval(32'h0);
        applyStimulus(1'b0);
        checkOutput("sat_pos", 32'h7FFF_FFFF, 1'b1);
        finishHandshake();

        setPairs(32'h7FFF_0000, 32'h8001_0000, 32'h7FFF_0000, 32'h8001_0000);
        startEval(32'h0);
        applyStimulus(1'b0);
        checkOutput("sat_neg", 32'h8000_0000, 1'b1);
        finishHandshake();

        setPairs(32'h0000_0001, 32'h0000_8000, 32'h0, 32'h0);
        startEval(32'h0);
        applyStimulus(1'b0);
        checkOutput("trunc_pos", 32'h0000_0000, 1'b0);
        finishHandshake();

        setPairs(32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 32'h0);
        startEval(32'h0);
        applyStimulus(1'b0);
        checkOutput("trunc_floor", 32'hFFFF_FFFF, 1'b0);
        finishHandshake();

        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < KT; i++) begin
                xArr[i] = randQ();
                wArr[i] = randQ();
            end
            b = randQ();
            startEval(b);
            applyStimulus(1'b1);
            refModel(b, expOut, expSat);
            checkOutput("rand", expOut, expSat);
            finishHandshake();
        end

        // Consumer stalls while start is waved around; HOLD must not move.
        for (int i = 0; i < KT; i++) begin
            xArr[i] = randQ();
            wArr[i] = randQ();
        end
        b = randQ();
        startEval(b);
        applyStimulus(1'b1);
        refModel(b, expOut, expSat);
        for (int c = 0; c < 5; c++) begin
            start = (c >= 2);
            bias  = $urandom();
            checkOutput("hold_stable", expOut, expSat);
            checkVal("hold_valid", 32'(outValid), 32'd1);
            checkVal("hold_ready", 32'(inReady), 32'd0);
            tick();
        end
        for (int i = 0; i < KT; i++) begin
            xArr[i] = randQ();
            wArr[i] = randQ();
        end
        b        = randQ();
        bias     = b;
        start    = 1'b1;
        outReady = 1'b1;
        tick();
        checkVal("hold_exit_valid", 32'(outValid), 32'd0);
        checkVal("hold_exit_idle", 32'(inReady), 32'd0);
        outReady = 1'b0;
        tick();
        start = 1'b0;
        checkVal("b2b_accum", 32'(inReady), 32'd1);
        applyStimulus(1'b1);
        refModel(b, expOut, expSat);
        checkOutput("b2b", expOut, expSat);
        finishHandshake();

        // Reset in the middle of accumulation, then a clean evaluation.
        setPairs(32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000);
        startEval(32'h0002_0000);
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1;
            xIn     = xArr[i];
            wIn     = wArr[i];
            tick();
        end
        inValid = 1'b0;
        rstN    = 1'b0;
        #1;
        checkVal("midrst_in_ready", 32'(inReady), 32'd0);
        checkVal("midrst_out_valid", 32'(outValid), 32'd0);
        checkVal("midrst_out", outVal, 32'd0);
        checkVal("midrst_sat", 32'(sat), 32'd0);
        #2;
        rstN = 1'b1;
        tick();
        checkVal("postrst_idle", 32'(inReady), 32'd0);
        checkVal("postrst_valid", 32'(outValid), 32'd0);
        inValid = 1'b1;
        xIn     = 32'h0100_0000;
        wIn     = 32'h0100_0000;
        tick();
        tick();
        inValid = 1'b0;
        for (int i = 0; i < KT; i++) begin
            xArr[i] = randQ();
            wArr[i] = randQ();
        end
        b = randQ();
        startEval(b);
        applyStimulus(1'b1);
        refModel(b, expOut, expSat);
        checkOutput("fresh", expOut, expSat);
        finishHandshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
